muldiv_iter: RTL and testbench

Parametrised iterative multiply/divide unit for the execute stage, the next generation of the 32-bit shift-add/restoring-subtract engine. It is generalised to `WIDTH`-bit operands and captures operands at acceptance, so the requester need not hold them. It adds a ready/done handshake, early termination for multiply, and a defined divide-by-zero result with a flag. It sits beside the ALU and stalls the pipeline while `ready_o` is low.

---
 rtl/muldiv_pkg.sv | 17 +
 rtl/muldiv_negate.sv | 13 +
 rtl/muldiv_iter.sv | 151 +++++++++++++++
 tb/tb_muldiv_iter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Pure declarations: no latency, no flow control.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Replicated to WIDTH bits to form the divide-by-zero quotient.
  localparam logic DBZ_QUOT_BIT = 1'b1;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement: out_val = neg ? -in_val : in_val.
// Combinational, zero latency, no flow control.
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] in_val,
  output logic [W-1:0] out_val
);

  assign out_val = neg ? (~in_val + W'(1)) : in_val;

endmodule

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiply / restoring divide; done one cycle after edge E0+n+1.
// Accepts start_i only while ready_o is high; no queueing, annul_i drops the operation.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               is_div_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic               ready_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               div_by_zero_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int W2    = 2 * WIDTH;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, n_mul;
  logic [W2-1:0]    acc_q, mcand_q;
  logic [WIDTH-1:0] op2_q;
  logic             is_div_q, neg_q_q, neg_r_q, dbz_q;

  logic             s1, s2, accept, div_zero, step_en, fix_en;
  logic [WIDTH-1:0] mag1, mag2, rem_fix, quo_fix;
  logic [WIDTH:0]   trial;
  logic [W2-1:0]    mul_next, div_next, prod_fix, fix_res;

  assign s1       = signed_i & opdata1_i[WIDTH-1];
  assign s2       = signed_i & opdata2_i[WIDTH-1];
  assign accept   = ready_o & start_i & ~annul_i;
  assign div_zero = (is_div_i == OP_DIV) && (opdata2_i == '0);

  muldiv_negate #(.W(WIDTH)) u_mag1 (.neg(s1), .in_val(opdata1_i), .out_val(mag1));
  muldiv_negate #(.W(WIDTH)) u_mag2 (.neg(s2), .in_val(opdata2_i), .out_val(mag2));

  // Early-termination count: one iteration per multiplier bit up to its MSB.
  always_comb begin
    n_mul = CNT_W'(1);
    for (int i = 0; i < WIDTH; i++) begin
      if (mag2[i]) n_mul = CNT_W'(i + 1);
    end
  end

  // acc_q holds {partial remainder, dividend/quotient} during a divide.
  assign trial    = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, op2_q};
  assign div_next = trial[WIDTH] ? {acc_q[W2-2:0], 1'b0}
                                 : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  assign mul_next = acc_q + (op2_q[0] ? mcand_q : '0);

  muldiv_negate #(.W(W2))    u_prod (.neg(neg_q_q), .in_val(acc_q), .out_val(prod_fix));
  muldiv_negate #(.W(WIDTH)) u_rem  (.neg(neg_r_q), .in_val(acc_q[W2-1:WIDTH]), .out_val(rem_fix));
  muldiv_negate #(.W(WIDTH)) u_quo  (.neg(neg_q_q), .in_val(acc_q[WIDTH-1:0]), .out_val(quo_fix));

  assign fix_res = (is_div_q == OP_DIV) ? {rem_fix, quo_fix} : prod_fix;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    step_en = 1'b0;
    fix_en  = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (accept) state_d = div_zero ? FIX : CALC;
      end
      CALC: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          step_en = 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        fix_en  = ~annul_i;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q         <= '0;
      acc_q         <= '0;
      mcand_q       <= '0;
      op2_q         <= '0;
      is_div_q      <= 1'b0;
      neg_q_q       <= 1'b0;
      neg_r_q       <= 1'b0;
      dbz_q         <= 1'b0;
      result_o      <= '0;
      done_o        <= 1'b0;
      div_by_zero_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (accept) begin
        is_div_q <= is_div_i;
        dbz_q    <= div_zero;
        op2_q    <= mag2;
        if (div_zero) begin
          // Dividend passes through untouched as the remainder.
          acc_q   <= {opdata1_i, {WIDTH{DBZ_QUOT_BIT}}};
          neg_q_q <= 1'b0;
          neg_r_q <= 1'b0;
          cnt_q   <= '0;
        end else if (is_div_i == OP_DIV) begin
          acc_q   <= {{WIDTH{1'b0}}, mag1};
          neg_q_q <= s1 ^ s2;
          neg_r_q <= s1;
          cnt_q   <= CNT_W'(WIDTH);
        end else begin
          acc_q   <= '0;
          mcand_q <= {{WIDTH{1'b0}}, mag1};
          neg_q_q <= s1 ^ s2;
          neg_r_q <= s1;
          cnt_q   <= n_mul;
        end
      end
      if (step_en) begin
        cnt_q <= cnt_q - CNT_W'(1);
        if (is_div_q == OP_DIV) begin
          acc_q <= div_next;
        end else begin
          acc_q   <= mul_next;
          mcand_q <= mcand_q << 1;
          op2_q   <= op2_q >> 1;
        end
      end
      if (fix_en) begin
        result_o      <= fix_res;
        div_by_zero_o <= dbz_q;
        done_o        <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter: directed ops push expected results, negedge monitors pop on done_o.
module tb_muldiv_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst32, rst16, start32, start16, annul, is_div, sgn;
  logic [31:0] a32, b32;
  logic [15:0] a16, b16;
  logic        rdy32, done32, dbz32, rdy16, done16, dbz16;
  logic [63:0] res32;
  logic [31:0] res16;

  muldiv_iter #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst32), .start_i(start32), .annul_i(annul), .is_div_i(is_div),
    .signed_i(sgn), .opdata1_i(a32), .opdata2_i(b32), .ready_o(rdy32),
    .done_o(done32), .result_o(res32), .div_by_zero_o(dbz32)
  );

  muldiv_iter #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst16), .start_i(start16), .annul_i(annul), .is_div_i(is_div),
    .signed_i(sgn), .opdata1_i(a16), .opdata2_i(b16), .ready_o(rdy16),
    .done_o(done16), .result_o(res16), .div_by_zero_o(dbz16)
  );

  typedef struct {
    int          id;
    logic [63:0] res;
    logic        dbz;
    int          due;
  } exp_t;

  exp_t sb32[$];
  exp_t sb16[$];
  int   cyc    = 0;
  int   passed = 0;
  int   total  = 0;
  int   op_id  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin : mon32
    exp_t e;
    if (done32 === 1'b1) begin
      if (sb32.size() == 0) begin
        chk("done32_unexpected", {63'd0, done32}, 64'd0);
      end else begin
        e = sb32.pop_front();
        chk($sformatf("op%0d_result", e.id), res32, e.res);
        chk($sformatf("op%0d_dbz", e.id), {63'd0, dbz32}, {63'd0, e.dbz});
        chk($sformatf("op%0d_done_cycle", e.id), 64'(cyc), 64'(e.due));
        chk($sformatf("op%0d_ready_at_done", e.id), {63'd0, rdy32}, 64'd1);
      end
    end
  end

  always @(negedge clk) begin : mon16
    exp_t e;
    if (done16 === 1'b1) begin
      if (sb16.size() == 0) begin
        chk("done16_unexpected", {63'd0, done16}, 64'd0);
      end else begin
        e = sb16.pop_front();
        chk($sformatf("op%0d_result16", e.id), {32'd0, res16}, e.res);
        chk($sformatf("op%0d_dbz16", e.id), {63'd0, dbz16}, {63'd0, e.dbz});
        chk($sformatf("op%0d_done_cycle16", e.id), 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic wait_rdy32();
    int k = 0;
    while (rdy32 !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("ready32_wait", {63'd0, rdy32}, 64'd1);
  endtask

  task automatic wait_rdy16();
    int k = 0;
    while (rdy16 !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("ready16_wait", {63'd0, rdy16}, 64'd1);
  endtask

  // n is the iteration count; done is due in the cycle after edge E0+n+1.
  task automatic issue32(input logic d, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] r, input logic z, input int n, input bit track);
    exp_t e;
    wait_rdy32();
    is_div = d; sgn = s; a32 = a; b32 = b; start32 = 1'b1;
    if (track) begin
      e.id = op_id; e.res = r; e.dbz = z; e.due = cyc + n + 2;
      sb32.push_back(e);
    end
    op_id++;
    @(negedge clk);
    start32 = 1'b0;
  endtask

  task automatic issue16(input logic d, input logic s, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] r, input logic z, input int n, input bit track);
    exp_t e;
    wait_rdy16();
    is_div = d; sgn = s; a16 = a; b16 = b; start16 = 1'b1;
    if (track) begin
      e.id = op_id; e.res = {32'd0, r}; e.dbz = z; e.due = cyc + n + 2;
      sb16.push_back(e);
    end
    op_id++;
    @(negedge clk);
    start16 = 1'b0;
  endtask

  initial begin
    int k;
    rst32 = 1'b0; rst16 = 1'b0; start32 = 1'b0; start16 = 1'b0; annul = 1'b0;
    is_div = 1'b0; sgn = 1'b0; a32 = '0; b32 = '0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    chk("reset_result", res32, 64'd0);
    chk("reset_done", {63'd0, done32}, 64'd0);
    chk("reset_dbz", {63'd0, dbz32}, 64'd0);
    chk("reset_ready", {63'd0, rdy32}, 64'd1);
    rst32 = 1'b1; rst16 = 1'b1;
    @(negedge clk);

    issue32(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, 32, 1);
    issue32(0, 0, 32'd3, 32'd1, 64'd3, 0, 1, 1);
    issue32(0, 0, 32'd7, 32'd0, 64'd0, 0, 1, 1);
    issue32(1, 1, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0, 32, 1);
    issue32(1, 0, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, 1, 0, 1);
    issue32(1, 0, 32'd6, 32'd3, 64'h0000_0000_0000_0002, 0, 32, 1);
    chk("dbz_held", {63'd0, dbz32}, 64'd1);
    chk("result_held", res32, 64'h0000_0005_FFFF_FFFF);
    issue32(1, 0, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 0, 32, 1);
    // A start while busy must be dropped without disturbing the divide.
    is_div = 1'b0; a32 = 32'd9; b32 = 32'd9; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    issue32(0, 1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 0, 3, 1);
    issue32(0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFA, 64'd24, 0, 3, 1);
    issue32(0, 1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0, 32, 1);
    issue32(1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0, 32, 1);
    issue32(1, 1, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 0, 32, 1);

    // Annul in the 10th CALC cycle.
    issue32(0, 0, 32'h0001_2345, 32'hFFFF_FFFF, 64'd0, 0, 32, 0);
    repeat (9) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    chk("annul_ready", {63'd0, rdy32}, 64'd1);
    chk("annul_no_done", {63'd0, done32}, 64'd0);
    chk("annul_result_kept", res32, 64'h0000_0001_FFFF_FFFD);
    issue32(0, 0, 32'h10, 32'h10, 64'h100, 0, 5, 1);

    wait_rdy32();
    annul = 1'b1; start32 = 1'b1; is_div = 1'b0; a32 = 32'd2; b32 = 32'd2;
    @(negedge clk);
    start32 = 1'b0; annul = 1'b0;
    chk("idle_annul_blocks_start", {63'd0, rdy32}, 64'd1);
    issue32(1, 1, 32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF, 1, 0, 1);

    issue16(1, 1, 16'h8000, 16'hFFFF, 32'h0000_8000, 0, 16, 1);
    issue16(0, 0, 16'h00FF, 16'h7FFF, 32'd0, 0, 15, 0);
    repeat (4) @(negedge clk);
    #2 rst16 = 1'b0;
    #1;
    chk("rst16_result", {32'd0, res16}, 64'd0);
    chk("rst16_done", {63'd0, done16}, 64'd0);
    chk("rst16_dbz", {63'd0, dbz16}, 64'd0);
    chk("rst16_ready", {63'd0, rdy16}, 64'd1);
    @(negedge clk);
    rst16 = 1'b1;
    @(negedge clk);
    issue16(0, 0, 16'd9, 16'd9, 32'h51, 0, 4, 1);

    k = 0;
    while ((sb32.size() != 0 || sb16.size() != 0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    chk("sb32_drained", 64'(sb32.size()), 64'd0);
    chk("sb16_drained", 64'(sb16.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
